// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM plus MMIO page (timer, LED, status); timer built only with DMEM_TIMER_EN
module dmem_mmio #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [15:0] IO_PAGE     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  led,
    output logic        irq,
    output logic        buserr
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
`ifdef DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          misaligned;
    logic          is_ram;
    logic          io_hit;
    logic          bad;
    logic          sel_cnt;
    logic          sel_cmp;
    logic          sel_ctrl;
    logic          sel_status;
    logic          sel_led;

    logic [31:0]   cnt_q;
    logic [31:0]   cmp_q;
    logic [2:0]    ctrl_q;
    logic          match_now;
    logic          match_q;
    logic          err_q;
    logic [7:0]    led_q;

    assign idx = adr[AW+1:2];

    // Address decode in priority order: alignment, RAM window, I/O page registers, else unmapped.
    always_comb begin
        misaligned = (adr[1:0] != 2'b00);
        is_ram     = !misaligned && (adr < RAM_BYTES);
        io_hit     = !misaligned && !is_ram && (adr[31:16] == IO_PAGE);
        sel_cnt    = TIMER && io_hit && (adr[15:0] == 16'h0000);
        sel_cmp    = TIMER && io_hit && (adr[15:0] == 16'h0004);
        sel_ctrl   = TIMER && io_hit && (adr[15:0] == 16'h0008);
        sel_status = io_hit && (adr[15:0] == 16'h000C);
        sel_led    = io_hit && (adr[15:0] == 16'h0010);
        bad        = !is_ram && !(sel_cnt || sel_cmp || sel_ctrl || sel_status || sel_led);
    end

    // Combinational load mux; unmapped and misaligned reads return zero.
    always_comb begin
        rd = '0;
        if (is_ram) begin
            rd = mem[idx];
        end else if (sel_cnt) begin
            rd = cnt_q;
        end else if (sel_cmp) begin
            rd = cmp_q;
        end else if (sel_ctrl) begin
            rd = {29'd0, ctrl_q};
        end else if (sel_status) begin
            rd = {30'd0, err_q, match_q};
        end else if (sel_led) begin
            rd = {24'd0, led_q};
        end
    end

    // RAM word store; contents survive reset but a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && we && is_ram) begin
            mem[idx] <= wd;
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] cnt_next;

    // Next count: match is judged on the pre-store value, then a CNT store overrides it.
    always_comb begin
        match_now = ctrl_q[0] && (cnt_q == cmp_q);
        cnt_next  = cnt_q;
        if (ctrl_q[0]) begin
            cnt_next = (match_now && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
        end
        if (we && sel_cnt) begin
            cnt_next = wd;
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 32'd0;
            cmp_q  <= 32'hFFFF_FFFF;
            ctrl_q <= 3'd0;
        end else begin
            cnt_q <= cnt_next;
            if (we && sel_cmp) begin
                cmp_q <= wd;
            end
            if (we && sel_ctrl) begin
                ctrl_q <= wd[2:0];
            end
        end
    end

    assign irq = match_q & ctrl_q[2];
`else
    assign match_now = 1'b0;
    assign cnt_q     = 32'd0;
    assign cmp_q     = 32'hFFFF_FFFF;
    assign ctrl_q    = 3'd0;
    assign irq       = 1'b0;
`endif

    // Status and LED: sticky bits clear on write-1 but a same-cycle event keeps them set.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
            err_q   <= 1'b0;
            led_q   <= 8'd0;
        end else begin
            match_q <= (match_q & ~(we & sel_status & wd[0])) | match_now;
            err_q   <= (err_q & ~(we & sel_status & wd[1])) | bad;
            if (we && sel_led) begin
                led_q <= wd[7:0];
            end
        end
    end

    assign led    = led_q;
    assign buserr = err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - randomized and directed bench for dmem_mmio against a behavioural model
module tb_dmem_mmio;
`ifdef DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam int WORDS = 64;

    localparam int K_RAM = 0, K_CNT = 1, K_CMP = 2, K_CTRL = 3, K_STAT = 4, K_LED = 5, K_BAD = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  led;
    logic        irq;
    logic        buserr;

    int total = 0;
    int bad = 0;

    logic [31:0] m_ram [WORDS];
    bit          m_ok  [WORDS];
    logic [31:0] m_cnt, m_cmp;
    logic [2:0]  m_ctrl;
    bit          m_match, m_err;
    logic [7:0]  m_led;
    bit          model_valid = 1'b0;

    logic [31:0] s_rd;
    logic [7:0]  s_led;
    logic        s_irq, s_err;

    dmem_mmio #(.DEPTH_WORDS(WORDS), .IO_PAGE(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .we(we), .adr(adr), .wd(wd),
        .rd(rd), .led(led), .irq(irq), .buserr(buserr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] a);
        if (a % 4 != 0) return K_BAD;
        if (a < WORDS * 4) return K_RAM;
        if (a[31:16] != 16'hFFFF) return K_BAD;
        case (a[15:0])
            16'h0000: return TIMER ? K_CNT : K_BAD;
            16'h0004: return TIMER ? K_CMP : K_BAD;
            16'h0008: return TIMER ? K_CTRL : K_BAD;
            16'h000C: return K_STAT;
            16'h0010: return K_LED;
            default:  return K_BAD;
        endcase
    endfunction

    // Advance the model by one clock edge from the inputs present at that edge.
    task automatic model_step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        int          k;
        bit          hit;
        bit          n_match, n_err;
        logic [31:0] n_cnt;
        if (r) begin
            m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0;
            m_match = 0; m_err = 0; m_led = 0;
            model_valid = 1'b1;
            return;
        end
        k = classify(a);
        hit = 0;
        n_cnt = m_cnt;
        if (m_ctrl[0]) begin
            if (m_cnt == m_cmp) begin
                hit = 1;
                n_cnt = m_ctrl[1] ? 32'd0 : m_cnt + 1;
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        n_match = m_match;
        n_err = m_err;
        if (w) begin
            case (k)
                K_RAM:  begin m_ram[a / 4] = d; m_ok[a / 4] = 1; end
                K_CNT:  n_cnt = d;
                K_CMP:  m_cmp = d;
                K_CTRL: m_ctrl = d[2:0];
                K_STAT: begin if (d[0]) n_match = 0; if (d[1]) n_err = 0; end
                K_LED:  m_led = d[7:0];
                default: ;
            endcase
        end
        if (hit) n_match = 1;
        if (k == K_BAD) n_err = 1;
        m_cnt = n_cnt;
        m_match = n_match;
        m_err = n_err;
    endtask

    always @(posedge clk) model_step(reset, we, adr, wd);

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int          k;
        logic [31:0] e;
        if (model_valid) begin
            k = classify(adr);
            e = 0;
            case (k)
                K_RAM:  e = m_ram[adr / 4];
                K_CNT:  e = m_cnt;
                K_CMP:  e = m_cmp;
                K_CTRL: e = {29'd0, m_ctrl};
                K_STAT: e = {30'd0, m_err, m_match};
                K_LED:  e = {24'd0, m_led};
                default: e = 0;
            endcase
            if (k != K_RAM || m_ok[adr / 4]) chk("model_rd", rd, e);
            chk("model_led", {24'd0, led}, {24'd0, m_led});
            chk("model_irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
            chk("model_buserr", {31'd0, buserr}, {31'd0, m_err});
        end
    end

    // One bus cycle: drive inputs, sample outputs mid-cycle, then cross the edge.
    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        reset = r; we = w; adr = a; wd = d;
        @(negedge clk);
        s_rd = rd; s_led = led; s_irq = irq; s_err = buserr;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] IO = 32'hFFFF_0000;

    initial begin
        logic [31:0] a, d;
        logic [31:0] ar_seq [6];
        for (int i = 0; i < WORDS; i++) m_ok[i] = 0;
        reset = 1; we = 0; adr = 0; wd = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0);
        chk("reset_led", {24'd0, led}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_buserr", {31'd0, buserr}, 32'd0);

        for (int i = 0; i < WORDS; i++) step(0, 1, i * 4, $urandom);

        // RAM store/load and read-during-write
        step(0, 1, 32'h8, 32'h1111_1111);
        step(0, 1, 32'h8, 32'hDEAD_BEEF);
        chk("ram_rdw_old", s_rd, 32'h1111_1111);
        step(0, 0, 32'h8, 0);
        chk("ram_load", s_rd, 32'hDEAD_BEEF);

        // error flag
        step(0, 0, 32'h2, 0);
        chk("misaligned_rd", s_rd, 32'd0);
        chk("err_before", {31'd0, s_err}, 32'd0);
        step(0, 1, IO + 32'h20, 32'h5);
        chk("err_after_load", {31'd0, s_err}, 32'd1);
        step(0, 0, 32'h8, 0);
        chk("err_stays", {31'd0, s_err}, 32'd1);
        step(0, 1, IO + 32'hC, 32'h2);
        step(0, 0, 32'h8, 0);
        chk("err_w1c", {31'd0, s_err}, 32'd0);

        // LED
        step(0, 1, IO + 32'h10, 32'h1A5);
        step(0, 0, IO + 32'h10, 0);
        chk("led_read", s_rd, 32'h0000_00A5);
        chk("led_out", {24'd0, s_led}, 32'h0000_00A5);

`ifdef DMEM_TIMER_EN
        // timer match with interrupt
        step(0, 1, IO + 32'h4, 32'd5);
        step(0, 1, IO + 32'h0, 32'd0);
        step(0, 1, IO + 32'h8, 32'd5);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, IO, 0);
            chk("tmr_cnt", s_rd, i);
            chk("tmr_irq", {31'd0, s_irq}, (i >= 6) ? 32'd1 : 32'd0);
        end
        step(0, 1, IO + 32'hC, 32'h1);
        step(0, 0, IO, 0);
        chk("tmr_irq_clr", {31'd0, s_irq}, 32'd0);

        // store to CNT on a matching cycle, then W1C on a matching cycle
        step(0, 1, IO + 32'h8, 32'd0);
        step(0, 1, IO + 32'h0, 32'd50);
        step(0, 1, IO + 32'h4, 32'd50);
        step(0, 1, IO + 32'h8, 32'd5);
        step(0, 1, IO + 32'h0, 32'd100);
        step(0, 0, IO, 0);
        chk("coll_cnt", s_rd, 32'd100);
        chk("coll_irq", {31'd0, s_irq}, 32'd1);
        step(0, 1, IO + 32'hC, 32'h1);
        step(0, 1, IO + 32'h4, 32'd104);
        chk("coll_cleared", {31'd0, s_irq}, 32'd0);
        step(0, 0, IO, 0);
        step(0, 1, IO + 32'hC, 32'h1);
        chk("coll_w1c_cnt", s_rd, 32'd0);
        step(0, 0, IO + 32'hC, 0);
        chk("coll_match_kept", s_rd, 32'h1);

        // auto-reload
        ar_seq[0] = 0; ar_seq[1] = 1; ar_seq[2] = 2; ar_seq[3] = 3; ar_seq[4] = 0; ar_seq[5] = 1;
        step(0, 1, IO + 32'h8, 32'd0);
        step(0, 1, IO + 32'h4, 32'd3);
        step(0, 1, IO + 32'h0, 32'd0);
        step(0, 1, IO + 32'h8, 32'd3);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, IO, 0);
            chk("autoreload", s_rd, ar_seq[i]);
        end

        // wrap
        step(0, 1, IO + 32'h8, 32'd0);
        step(0, 1, IO + 32'hC, 32'h3);
        step(0, 1, IO + 32'h4, 32'd0);
        step(0, 1, IO + 32'h0, 32'hFFFF_FFFE);
        step(0, 1, IO + 32'h8, 32'd1);
        step(0, 0, IO, 0);
        chk("wrap0", s_rd, 32'hFFFF_FFFE);
        step(0, 0, IO, 0);
        chk("wrap1", s_rd, 32'hFFFF_FFFF);
        step(0, 0, IO, 0);
        chk("wrap2", s_rd, 32'd0);
        step(0, 0, IO + 32'hC, 0);
        chk("wrap_match", s_rd, 32'h1);

        // reset mid-count with pending interrupt
        step(0, 1, IO + 32'h8, 32'd5);
        step(0, 1, IO + 32'h10, 32'hA5);
        step(0, 0, IO, 0);
        chk("pre_reset_irq", {31'd0, s_irq}, 32'd1);
`endif
        step(1, 1, IO + 32'h10, 32'h3C);
        step(0, 0, IO, 0);
        chk("rst_led", {24'd0, s_led}, 32'd0);
        chk("rst_irq", {31'd0, s_irq}, 32'd0);
        chk("rst_cnt", s_rd, 32'd0);
        step(0, 0, IO + 32'h4, 0);
        chk("rst_cmp", s_rd, TIMER ? 32'hFFFF_FFFF : 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = $urandom_range(0, WORDS - 1) * 4;
                4, 5, 6:    a = IO + $urandom_range(0, 5) * 4;
                7:          a = $urandom_range(0, 300);
                8:          a = IO + $urandom_range(0, 255);
                default:    a = $urandom;
            endcase
            d = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
            step($urandom_range(0, 255) == 0, $urandom_range(0, 1) == 1, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
